// File: rtl/ex_issue_queue.sv
// In-order issue queue between decode and execute: a FIFO of operand/control bundles.
// Optional same-cycle empty-queue bypass is enabled by defining EX_ISSUE_QUEUE_BYPASS_EN.
module ex_issue_queue #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_data1,
  input  logic [XLEN-1:0]            in_data2,
  input  logic [XLEN-1:0]            in_imm,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       in_compflg,
  output logic [XLEN-1:0]            out_data1,
  output logic [XLEN-1:0]            out_data2,
  output logic [XLEN-1:0]            out_imm,
  output logic [XLEN-1:0]            out_pc,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic                       out_compflg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = 4 * XLEN + CTRL_W + 1;

  logic [BW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] out_bundle;
  logic          empty, full;
  logic          bypass_take;
  logic          push, pop;

  assign in_bundle = {in_data1, in_data2, in_imm, in_pc, in_ctrl, in_compflg};
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = !full;

`ifdef EX_ISSUE_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming bundle; if consumed at once it is never stored.
  assign out_valid   = !empty || in_valid;
  assign out_bundle  = empty ? in_bundle : mem_q[rd_ptr_q];
  assign bypass_take = empty && in_valid && out_ready;
`else
  assign out_valid   = !empty;
  assign out_bundle  = mem_q[rd_ptr_q];
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid && in_ready && !bypass_take;
  assign pop  = out_valid && out_ready && !bypass_take;

  assign {out_data1, out_data2, out_imm, out_pc, out_ctrl, out_compflg} = out_bundle;
  assign count = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_q[wr_ptr_q] <= in_bundle;
    end
  end

endmodule

// File: tb/tb_ex_issue_queue.sv
// Directed, table-driven bench for ex_issue_queue (DEPTH=4); one line per transaction.
module tb_ex_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data1 = '0, in_data2 = '0, in_imm = '0, in_pc = '0, in_ctrl = '0;
  logic        in_compflg = 1'b0;
  logic [31:0] out_data1, out_data2, out_imm, out_pc, out_ctrl;
  logic        out_compflg;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_issue_queue #(.XLEN(32), .CTRL_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm), .in_pc(in_pc),
    .in_ctrl(in_ctrl), .in_compflg(in_compflg),
    .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_compflg(out_compflg),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  typedef struct {
    logic        rst_n, flush, iv, ordy;
    logic [31:0] pc;
    logic        chk, e_ir, e_ov;
    logic [2:0]  e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic o,
                              input logic [31:0] pc, input logic c, input logic ir,
                              input logic ov, input logic [2:0] cnt, input logic [31:0] epc);
    vec_t v;
    v.rst_n = r; v.flush = f; v.iv = iv; v.ordy = o; v.pc = pc;
    v.chk = c; v.e_ir = ir; v.e_ov = ov; v.e_cnt = cnt; v.e_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, then compare the outputs seen during that same cycle.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] p;
    logic        ok;
    @(negedge clk);
    rst_n = v.rst_n; flush = v.flush; in_valid = v.iv; out_ready = v.ordy;
    p = v.pc;
    in_pc = p; in_data1 = p + 32'd5; in_data2 = ~p; in_imm = p ^ 32'hA5A5;
    in_ctrl = p + 32'd1; in_compflg = p[2];
    #1;
    $display("%s: rst_n=%0b flush=%0b in_valid=%0b out_ready=%0b pc=0x%0h | in_ready=%0b out_valid=%0b count=%0d out_pc=0x%0h",
             tag, rst_n, flush, in_valid, out_ready, p, in_ready, out_valid, count, out_pc);
    if (v.chk) begin
      check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.e_ir});
      check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.e_ov});
      check({tag, " count"}, {29'd0, count}, {29'd0, v.e_cnt});
      if (v.e_ov) begin
        p  = v.e_pc;
        ok = (out_data1 === p + 32'd5) && (out_data2 === ~p) && (out_imm === (p ^ 32'hA5A5)) &&
             (out_ctrl === p + 32'd1) && (out_compflg === p[2]);
        check({tag, " out_pc"}, out_pc, p);
        check({tag, " bundle"}, {31'd0, ok}, 32'd1);
      end
    end
  endtask

`ifndef EX_ISSUE_QUEUE_BYPASS_EN
  vec_t tbl [27];
`endif

  initial begin
`ifndef EX_ISSUE_QUEUE_BYPASS_EN
    //            rst f  iv o  pc        chk ir ov cnt e_pc
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 1, 1, 32'h100, 1, 1, 0, 0, 32'h0);
    tbl[3]  = mk(1, 0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h100);
    tbl[4]  = mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0);
    tbl[5]  = mk(1, 0, 1, 0, 32'h0,   1, 1, 0, 0, 32'h0);
    tbl[6]  = mk(1, 0, 1, 0, 32'h4,   1, 1, 1, 1, 32'h0);
    tbl[7]  = mk(1, 0, 1, 0, 32'h8,   1, 1, 1, 2, 32'h0);
    tbl[8]  = mk(1, 0, 1, 0, 32'hC,   1, 1, 1, 3, 32'h0);
    tbl[9]  = mk(1, 0, 1, 0, 32'h10,  1, 0, 1, 4, 32'h0);
    tbl[10] = mk(1, 0, 1, 0, 32'h10,  1, 0, 1, 4, 32'h0);
    tbl[11] = mk(1, 0, 1, 1, 32'h10,  1, 0, 1, 4, 32'h0);
    tbl[12] = mk(1, 0, 1, 1, 32'h10,  1, 1, 1, 3, 32'h4);
    tbl[13] = mk(1, 0, 1, 1, 32'h14,  1, 1, 1, 3, 32'h8);
    tbl[14] = mk(1, 0, 1, 1, 32'h18,  1, 1, 1, 3, 32'hC);
    tbl[15] = mk(1, 0, 0, 1, 32'h0,   1, 1, 1, 3, 32'h10);
    tbl[16] = mk(1, 0, 0, 0, 32'h0,   1, 1, 1, 2, 32'h14);
    tbl[17] = mk(1, 0, 1, 0, 32'h1C,  1, 1, 1, 2, 32'h14);
    tbl[18] = mk(1, 1, 1, 0, 32'h20,  1, 1, 1, 3, 32'h14);
    tbl[19] = mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0);
    tbl[20] = mk(1, 0, 1, 0, 32'h24,  1, 1, 0, 0, 32'h0);
    tbl[21] = mk(1, 0, 1, 0, 32'h28,  1, 1, 1, 1, 32'h24);
    tbl[22] = mk(0, 0, 1, 1, 32'h2C,  1, 1, 1, 2, 32'h24);
    tbl[23] = mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0);
    tbl[24] = mk(1, 0, 1, 0, 32'h30,  1, 1, 0, 0, 32'h0);
    tbl[25] = mk(1, 0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h30);
    tbl[26] = mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 27; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Empty queue without bypass: the push only shows at the output a cycle later.
    apply(mk(1, 0, 1, 1, 32'h200, 1, 1, 0, 0, 32'h0),   "nobyp0");
    apply(mk(1, 0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h200), "nobyp1");
    apply(mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0),   "nobyp2");
`else
    apply(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0),   "byp_rst");
    apply(mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0),   "byp_idle");
    apply(mk(1, 0, 1, 1, 32'h200, 1, 1, 1, 0, 32'h200), "byp_take");
    apply(mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0),   "byp_after");
    apply(mk(1, 0, 1, 0, 32'h204, 1, 1, 1, 0, 32'h204), "byp_hold");
    apply(mk(1, 0, 1, 0, 32'h208, 1, 1, 1, 1, 32'h204), "byp_stored");
    apply(mk(1, 0, 0, 1, 32'h0,   1, 1, 1, 2, 32'h204), "byp_pop0");
    apply(mk(1, 0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h208), "byp_pop1");
    apply(mk(1, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0),   "byp_empty");
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
